// File: rtl/booth_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_arith_pkg
// Purpose  : Shared state encoding and default width for the Booth arithmetic
//            units (multiplier and divider use the same controller states).
// Revision : 1.0  initial release
// ============================================================================
package booth_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_SIGN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/booth_abs_neg.sv
`default_nettype none
// ============================================================================
// Module   : booth_abs_neg
// Purpose  : Combinational conditional two's-complement negate.
// Revision : 1.0  initial release
// ============================================================================
module booth_abs_neg #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule
`default_nettype wire

// File: rtl/booth_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : booth_signed_divider
// Purpose  : Sequential signed divider, one quotient bit per clock, then sign
//            fix. Optional macro BOOTH_DIV_ZERO_DETECT_EN bypasses B==0.
// Revision : 1.0  initial release
// ============================================================================
module booth_signed_divider
    import booth_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             ready,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic             load, step, finish;
    logic             sa, sb, ovf_pend, dz_pend;
    logic [WIDTH-1:0] bmag, qmag;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
    logic [WIDTH+1:0] rem_shift, trial;
    logic             b_zero, is_overflow;

    booth_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.in(A), .neg(A[WIDTH-1]), .out(a_abs));
    booth_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.in(B), .neg(B[WIDTH-1]), .out(b_abs));
    booth_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.in(qmag), .neg(sa ^ sb), .out(q_fix));
    booth_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.in(rem[WIDTH-1:0]), .neg(sa), .out(r_fix));

`ifdef BOOTH_DIV_ZERO_DETECT_EN
    assign b_zero = (B == '0);
`else
    assign b_zero = 1'b0;
`endif

    assign is_overflow = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);

    // One extra top bit so the trial subtraction sign is never lost
    assign rem_shift = {rem, qmag[WIDTH-1]};
    assign trial     = rem_shift - {2'b00, bmag};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = b_zero ? ST_SIGN : ST_RUN;
            ST_RUN:  if (count == CW'(1)) state_nxt = ST_SIGN;
            ST_SIGN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        load   = (state == ST_IDLE) && start;
        step   = (state == ST_RUN);
        finish = (state == ST_SIGN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sa          <= 1'b0;
            sb          <= 1'b0;
            ovf_pend    <= 1'b0;
            dz_pend     <= 1'b0;
            bmag        <= '0;
            qmag        <= '0;
            rem         <= '0;
            count       <= '0;
            Q           <= '0;
            R           <= '0;
            ready       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            ready <= finish;
            if (load) begin
                sa       <= A[WIDTH-1];
                sb       <= B[WIDTH-1];
                bmag     <= b_abs;
                count    <= CW'(WIDTH);
                ovf_pend <= is_overflow;
                dz_pend  <= b_zero;
                // Bypass pre-loads the remainder so the sign fix restores A
                rem      <= b_zero ? {1'b0, a_abs} : '0;
                qmag     <= b_zero ? '1 : a_abs;
            end else if (step) begin
                count <= count - CW'(1);
                qmag  <= {qmag[WIDTH-2:0], ~trial[WIDTH+1]};
                rem   <= trial[WIDTH+1] ? rem_shift[WIDTH:0] : trial[WIDTH:0];
            end else if (finish) begin
                Q           <= dz_pend ? '1 : q_fix;
                R           <= r_fix;
                overflow    <= ovf_pend;
                div_by_zero <= dz_pend;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_signed_divider
// Purpose  : Self-checking bench for booth_signed_divider (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_booth_signed_divider;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A, B;
    logic [W-1:0] Q, R;
    logic         ready, busy, overflow, div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    booth_signed_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .ready(ready), .busy(busy),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the documented special cases
    task automatic ref_div(input int a, input int b, output logic [W-1:0] q,
                           output logic [W-1:0] r, output logic ovf,
                           output logic dz, output int lat);
        int minv;
        minv = -(1 << (W-1));
        ovf  = 1'b0;
        dz   = 1'b0;
        lat  = W + 1;
        if (b == 0) begin
`ifdef BOOTH_DIV_ZERO_DETECT_EN
            q   = '1;
            dz  = 1'b1;
            lat = 1;
`else
            q = (a >= 0) ? W'(-1) : W'(1);
`endif
            r = W'(a);
        end else if (a == minv && b == -1) begin
            q   = W'(minv);
            r   = '0;
            ovf = 1'b1;
        end else begin
            q = W'(a / b);
            r = W'(a % b);
        end
    endtask

    task automatic issue(input int a, input int b);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output int edges);
        edges = 0;
        do begin
            @(posedge clock); #1;
            edges++;
        end while (!ready && edges < limit);
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        logic [W-1:0] eq, er;
        logic         eo, ed;
        int           lat, edges;
        ref_div(a, b, eq, er, eo, ed, lat);
        issue(a, b);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_ready(lat + 4, edges);
        check({tag, ".ready"}, 32'(ready), 32'd1);
        check({tag, ".lat"}, 32'(edges), 32'(lat));
        check({tag, ".q"}, 32'(Q), 32'(eq));
        check({tag, ".r"}, 32'(R), 32'(er));
        check({tag, ".ovf"}, 32'(overflow), 32'(eo));
        check({tag, ".dz"}, 32'(div_by_zero), 32'(ed));
        @(posedge clock); #1;
        check({tag, ".pulse"}, 32'(ready), 32'd0);
    endtask

    function automatic int to_signed(input int u);
        return (u >= (1 << (W-1))) ? u - (1 << W) : u;
    endfunction

    initial begin
        int edges, pulses, a, b;
        logic [W-1:0] q_seen, r_seen;

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst.q", 32'(Q), 32'd0);
        check("rst.r", 32'(R), 32'd0);
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        check("rst.dz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op("d7_2", 7, 2);
        run_op("dm7_2", -7, 2);
        run_op("d7_m2", 7, -2);
        run_op("dm7_m2", -7, -2);
        run_op("min_m1", -8, -1);
        run_op("min_3", -8, 3);
        run_op("d5_0", 5, 0);
        run_op("dm3_0", -3, 0);
        run_op("min_0", -8, 0);
        run_op("min_min", -8, -8);

        // Start while busy must be dropped
        issue(7, 2);
        @(posedge clock); #1;
        A = W'(1); B = W'(1); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        pulses = 0; q_seen = '0; r_seen = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (ready) begin
                pulses++;
                q_seen = Q;
                r_seen = R;
            end
        end
        check("ign.pulses", 32'(pulses), 32'd1);
        check("ign.q", 32'(q_seen), 32'd3);
        check("ign.r", 32'(r_seen), 32'd1);

        // Start during the ready cycle is accepted
        issue(7, 2);
        wait_ready(10, edges);
        check("b2b.ready1", 32'(ready), 32'd1);
        A = W'(6); B = W'(3); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_ready(10, edges);
        check("b2b.ready2", 32'(ready), 32'd1);
        check("b2b.lat", 32'(edges), 32'(W + 1));
        check("b2b.q", 32'(Q), 32'd2);
        check("b2b.r", 32'(R), 32'd0);
        @(posedge clock); #1;

        // Asynchronous reset in the middle of RUN
        issue(7, 2);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.q", 32'(Q), 32'd0);
        check("arst.r", 32'(R), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (ready) pulses++;
        end
        check("arst.noready", 32'(pulses), 32'd0);
        run_op("post_rst", 1, 1);

        for (int i = 0; i < 150; i++) begin
            a = to_signed(int'($urandom_range(0, (1 << W) - 1)));
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = -1;
                default: b = to_signed(int'($urandom_range(0, (1 << W) - 1)));
            endcase
            run_op("rnd", a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_signed_divider.md
Name: booth_signed_divider

Overview:
- Sequential signed integer divider; the inverse datapath to the team's radix-4 Booth multiplier.
- Takes a WIDTH-bit signed dividend and divisor and produces a truncating quotient and a remainder.
- Uses magnitude shift-subtract, one quotient bit per clock, followed by sign correction.
- Same start/ready handshake as the multiplier, so both share one arithmetic-unit controller.

Parameters:
WIDTH, 4, operand/result width in bits (signed, two's complement, WIDTH >= 2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  signed dividend; sampled with start
B  input  WIDTH  signed divisor; sampled with start
Q  output  WIDTH  signed quotient; held until next completion
R  output  WIDTH  signed remainder; held until next completion
ready  output  1  one-cycle completion pulse
busy  output  1  high while not IDLE
overflow  output  1  registered with Q/R; A = -2^(WIDTH-1) and B = -1
div_by_zero  output  1  registered with Q/R; 0 when macro absent

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, Q=0, R=0, ready=0, overflow=0, div_by_zero=0, internal regs 0. A reset mid-operation aborts the operation with no ready pulse.
- States: IDLE, RUN, SIGN.
- IDLE:
  - ready<=0.
  - If start: latch sA=A[WIDTH-1] and sB=B[WIDTH-1]; latch |A| and |B| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1)); clear the partial remainder (WIDTH+1 bits); count<=WIDTH; go to RUN.
- RUN, each cycle:
  - Shift {rem, qmag} left by 1.
  - trial = rem - |B|. If trial is non-negative, rem<=trial and qmag[0]<=1; else qmag[0]<=0.
  - count decrements; go to SIGN when count==1.
- SIGN:
  - Q <= (sA^sB) ? -qmag : qmag, truncated to WIDTH.
  - R <= sA ? -rem : rem, truncated to WIDTH.
  - Register overflow and div_by_zero; ready<=1; go to IDLE.
- Latency: start sampled at edge N gives ready high after edge N+WIDTH+1, for exactly one cycle.
- start while busy is ignored, with no queueing. start in the ready cycle (state is IDLE) is accepted, so back-to-back throughput is WIDTH+1 cycles.
- Results: quotient truncates toward zero; the remainder takes the sign of the dividend; A = Q*B + R whenever B != 0 and not overflow.
- Overflow case (min / -1): Q = -2^(WIDTH-1) (wraps), R = 0, overflow=1. Full latency.
- B = 0 without the macro: the natural algorithm result. qmag is all ones and R=A, so Q=-1 if A>=0, else Q=+1. div_by_zero=0. Full latency.

Optional Feature:
- Macro: BOOTH_DIV_ZERO_DETECT_EN.
- Defined: in IDLE, start with B==0 goes directly to SIGN, skipping RUN. Outputs Q = all ones (-1), R = A, div_by_zero=1, overflow=0. ready is high after edge N+1.
- Undefined: no bypass; div_by_zero is tied 0; B=0 follows the natural result above.

Decomposition:
- Package booth_arith_pkg: state encoding (IDLE/RUN/SIGN) shared with the multiplier controller; default WIDTH constant.
- Sub-module booth_abs_neg: combinational conditional two's-complement negate (in, neg, out). Instantiated for |A|, |B|, the Q sign fix and the R sign fix.

Test Plan (WIDTH=4):
- A=7, B=2, start 1 cycle -> ready after 5 edges; Q=3, R=1, overflow=0.
- A=-7,B=2 -> Q=-3,R=-1; A=7,B=-2 -> Q=-3,R=1; A=-7,B=-2 -> Q=3,R=-1.
- A=-8, B=-1 -> Q=-8, R=0, overflow=1. Also A=-8, B=3 -> Q=-2, R=-2.
- A=5, B=0:
  - Macro on: ready after 1 edge, Q=-1, R=5, div_by_zero=1.
  - Macro off: after 5 edges, Q=-1, R=5.
  - Macro off, A=-3, B=0: Q=1, R=-3.
- Second start pulse 2 cycles after the first -> ignored, only one ready pulse. Start held during the ready cycle with A=6, B=3 -> new op accepted, Q=2, R=0 after 5 more edges.
- Reset asserted 2 cycles into RUN -> busy=0, Q=R=0 at once; no ready pulse; next start (A=1, B=1) gives Q=1, R=0.
